// File: rtl/serial_add_ctrl.sv
// ============================================================================
// Module   : serial_add_ctrl
// Brief    : Bit-serial adder controller driving one external FullAdder cell,
//            LSB first, with valid/ready handshakes on operands and result.
//            Optional signed-overflow flag enabled by macro SERIAL_ADD_OVF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_s,
  input  logic             fa_cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] sum_sh_q;
  logic [WIDTH-1:0] sum_sh_d;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             cout_q;
  logic             in_ready_q;
  logic             out_valid_q;

  // Sum bits enter at the MSB so bit 0 lands at position 0 after WIDTH shifts.
  assign sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_sh_q    <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_sh_q     <= a;
            b_sh_q     <= b;
            carry_q    <= cin;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          sum_sh_q <= sum_sh_d;
          carry_q  <= fa_cout;
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
            sum_q       <= sum_sh_d;
            cout_q      <= fa_cout;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_q;

  // On the last RUN cycle carry_q is the carry into the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state_q == RUN && cnt_q == LAST_BIT) begin
      ovf_q <= carry_q ^ fa_cout;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign fa_a      = (state_q == RUN) & a_sh_q[0];
  assign fa_b      = (state_q == RUN) & b_sh_q[0];
  assign fa_cin    = (state_q == RUN) & carry_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
// ============================================================================
// Module   : tb_serial_add_ctrl
// Brief    : Self-checking bench for serial_add_ctrl with a FullAdder cell model
//            and an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         cin_in = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         fa_a, fa_b, fa_cin, fa_s, fa_cout;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // External FullAdder cell
  assign fa_s    = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_in),
    .b         (b_in),
    .cin       (cin_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .fa_a      (fa_a),
    .fa_b      (fa_b),
    .fa_cin    (fa_cin),
    .fa_s      (fa_s),
    .fa_cout   (fa_cout)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction: accept, WIDTH RUN cycles, DONE held for 'hold'
  // cycles with out_ready low, then release.
  task automatic do_op(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                       input logic ci, input int hold, input bit spurious);
    logic [W:0]   full;
    logic [W-1:0] es;
    logic         ec, eo;
    full = {1'b0, a_v} + {1'b0, b_v} + {{W{1'b0}}, ci};
    es   = full[W-1:0];
    ec   = full[W];
`ifdef SERIAL_ADD_OVF_EN
    eo   = (a_v[W-1] == b_v[W-1]) && (es[W-1] != a_v[W-1]);
`else
    eo   = 1'b0;
`endif
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1'b1);
    a_in = a_v; b_in = b_v; cin_in = ci; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a_in = W'($urandom); b_in = W'($urandom); cin_in = 1'($urandom);
    for (int k = 0; k < W; k++) begin
      chk("fa_a_bit", fa_a, a_v[k]);
      chk("fa_b_bit", fa_b, b_v[k]);
      chk("run_out_valid", out_valid, 1'b0);
      chk("run_in_ready", in_ready, 1'b0);
      if (spurious && k == 2) begin
        a_in = 8'h01; b_in = 8'h01; in_valid = 1'b1;
      end
      if (spurious && k == 3) in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    chk("latency_out_valid", out_valid, 1'b1);
    chk("sum", sum, es);
    chk("cout", cout, ec);
    chk("ovf", ovf, eo);
    chk("fa_done", {fa_a, fa_b, fa_cin}, 3'b000);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk("hold_out_valid", out_valid, 1'b1);
      chk("hold_sum", {cout, sum}, {ec, es});
      chk("hold_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("release_out_valid", out_valid, 1'b0);
    chk("release_in_ready", in_ready, 1'b1);
    chk("sum_kept", {cout, sum}, {ec, es});
    // Exactly one out_valid pulse: stays low while idle
    @(posedge clk);
    #1;
    chk("single_pulse", out_valid, 1'b0);
  endtask

  initial begin
    #12;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_outputs", {out_valid, sum, cout, ovf, fa_a, fa_b, fa_cin}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(8'h35, 8'h4A, 1'b0, 0, 1'b0);
    do_op(8'hFF, 8'h01, 1'b0, 0, 1'b0);
    do_op(8'hFF, 8'hFF, 1'b1, 0, 1'b0);
    do_op(8'h35, 8'h4A, 1'b0, 5, 1'b0);
    do_op(8'h10, 8'h20, 1'b0, 0, 1'b1);
    do_op(8'h7F, 8'h01, 1'b0, 0, 1'b0);
    do_op(8'h80, 8'hFF, 1'b0, 0, 1'b0);

    // Reset asserted mid-RUN
    @(negedge clk);
    a_in = 8'hAA; b_in = 8'h55; cin_in = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_in_ready", in_ready, 1'b1);
    chk("async_rst_outputs", {out_valid, sum, cout, ovf, fa_a, fa_b, fa_cin}, '0);
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clk);
      #1;
      chk("rst_no_valid", out_valid, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_op(8'h01, 8'h02, 1'b0, 0, 1'b0);

    for (int r = 0; r < 20; r++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
